// File: rtl/mul_pipe.sv
// Fully pipelined WIDTH x WIDTH integer multiplier with per-operand signedness and a sideband tag.
// The multiplier operand is consumed in STAGES equal bit slices, one shift-add slice per stage.
module mul_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     src,
    input  logic [WIDTH-1:0]     sink,
    input  logic                 src_signed,
    input  logic                 sink_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   dest,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned BW = WIDTH + 1;
    localparam int unsigned SL = (BW + STAGES - 1) / STAGES;

    logic              advance_c;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [PW-1:0]     a_q   [STAGES];
    logic [PW-1:0]     a_d   [STAGES];
    logic [BW-1:0]     b_q   [STAGES];
    logic [BW-1:0]     b_d   [STAGES];
    logic [PW-1:0]     acc_q [STAGES];
    logic [PW-1:0]     acc_d [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    // Adds one slice of partial products; bit WIDTH of the extended multiplier has negative weight.
    function automatic logic [PW-1:0] slice_acc(input logic [PW-1:0] acc,
                                                input logic [PW-1:0] a,
                                                input logic [BW-1:0] b,
                                                input int unsigned   lo);
        logic [PW-1:0] sum;
        logic [BW-1:0] bs;
        sum = acc;
        bs  = b >> lo;
        for (int unsigned j = 0; j < SL; j++) begin
            if (bs[j]) begin
                if (lo + j == WIDTH) begin
                    sum = sum - (a << (lo + j));
                end else begin
                    sum = sum + (a << (lo + j));
                end
            end
        end
        return sum;
    endfunction

    assign advance_c = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = advance_c;
    assign out_valid = vld_q[STAGES-1];
    assign dest      = acc_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

    // Data only loads behind a valid bit, so idle inputs never reach the result registers.
    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        tag_d = tag_q;
        if (advance_c) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                a_d[0]   = {{WIDTH{src_signed & src[WIDTH-1]}}, src};
                b_d[0]   = {sink_signed & sink[WIDTH-1], sink};
                acc_d[0] = slice_acc('0, a_d[0], b_d[0], 32'd0);
                tag_d[0] = in_tag;
            end
            for (int unsigned s = 1; s < STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    a_d[s]   = a_q[s-1];
                    b_d[s]   = b_q[s-1];
                    acc_d[s] = slice_acc(acc_q[s-1], a_q[s-1], b_q[s-1], s * SL);
                    tag_d[s] = tag_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q           <= '0;
            acc_q[STAGES-1] <= '0;
            tag_q[STAGES-1] <= '0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            tag_q <= tag_d;
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: three configurations run side by side, each with directed
// corner cases followed by randomized traffic checked against a plain-arithmetic model.
module tb_mul_pipe;

    localparam int unsigned TW    = 5;
    localparam int unsigned NRAND = 10000;

    logic clk;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned W  = (g == 0) ? 32 : (g == 1) ? 16 : 64;
        localparam int unsigned S  = (g == 0) ? 4 : (g == 1) ? 1 : 6;
        localparam int unsigned PW = 2 * W;

        logic          rst, in_valid, in_ready, src_signed, sink_signed, out_valid, out_ready;
        logic [W-1:0]  src, sink;
        logic [TW-1:0] in_tag, out_tag;
        logic [PW-1:0] dest;
        logic [PW-1:0] exp_d[$];
        logic [TW-1:0] exp_t[$];
        bit            done;

        logic [W-1:0]  a, b, ones, mn;
        logic          sa, sb, seen;
        logic [PW-1:0] hd;
        logic [TW-1:0] ht;
        int unsigned   n_acc, cyc_n;

        mul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .src        (src),
            .sink       (sink),
            .src_signed (src_signed),
            .sink_signed(sink_signed),
            .in_tag     (in_tag),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .dest       (dest),
            .out_tag    (out_tag)
        );

        // Exact product of the two extended operands, truncated to 2*W bits.
        function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                                  input logic sx, input logic sy);
            logic signed [W:0]     ex, ey;
            logic signed [2*W+1:0] p;
            ex = {sx & x[W-1], x};
            ey = {sy & y[W-1], y};
            p  = $signed({{(W+1){ex[W]}}, ex}) * $signed({{(W+1){ey[W]}}, ey});
            return p[PW-1:0];
        endfunction

        function automatic logic [W-1:0] pick();
            logic [W-1:0] v;
            v = W'({$urandom(), $urandom()});
            case ($urandom_range(0, 7))
                0:       v = '0;
                1:       v = '1;
                2:       v = {1'b1, {(W-1){1'b0}}};
                3:       v = {1'b0, {(W-1){1'b1}}};
                default: ;
            endcase
            return v;
        endfunction

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic idle();
            in_valid = 1'b0;
            src      = pick();
            sink     = pick();
        endtask

        // Holds the op on the inputs until accepted; the expected result is queued at acceptance.
        task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sx,
                             input logic sy, input logic [TW-1:0] t, input logic [PW-1:0] e);
            bit acc;
            src = x; sink = y; src_signed = sx; sink_signed = sy; in_tag = t; in_valid = 1'b1;
            acc = 1'b0;
            for (int n = 0; n < 64 && !acc; n++) begin
                @(negedge clk);
                if (in_ready) begin
                    acc = 1'b1;
                    exp_d.push_back(e);
                    exp_t.push_back(t);
                end
                step();
            end
            if (!acc) fail($sformatf("cfg%0d issue timeout tag=%0d", g, t));
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (exp_d.size() != 0 && n < 300) begin
                step();
                n++;
            end
            if (exp_d.size() != 0) fail($sformatf("cfg%0d drain timeout left=%0d", g, exp_d.size()));
        endtask

        always @(negedge clk) begin
            if (!rst && out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    fail($sformatf("cfg%0d unexpected result tag=%0d", g, out_tag));
                end else begin
                    chk($sformatf("cfg%0d dest tag%0d", g, exp_t[0]), 128'(dest), 128'(exp_d[0]));
                    chk($sformatf("cfg%0d out_tag", g), 128'(out_tag), 128'(exp_t[0]));
                    void'(exp_d.pop_front());
                    void'(exp_t.pop_front());
                end
            end
        end

        initial begin
            done = 1'b0;
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            src = '0; sink = '0; src_signed = 1'b0; sink_signed = 1'b0; in_tag = '0;
            ones = '1;
            mn   = {1'b1, {(W-1){1'b0}}};
            repeat (2) step();
            rst = 1'b0;
            @(negedge clk);
            chk($sformatf("cfg%0d reset out_valid", g), 128'(out_valid), 128'(0));
            chk($sformatf("cfg%0d reset dest", g), 128'(dest), 128'(0));
            chk($sformatf("cfg%0d reset out_tag", g), 128'(out_tag), 128'(0));
            step();

            // Single op: latency and one-cycle output pulse.
            out_ready = 1'b1;
            issue(W'(1), {{(W/2){1'b0}}, {(W/2){1'b1}}}, 1'b1, 1'b1, TW'(0),
                  {{(PW-W/2){1'b0}}, {(W/2){1'b1}}});
            idle();
            for (int k = 0; k <= int'(S); k++) begin
                @(negedge clk);
                chk($sformatf("cfg%0d latency k=%0d", g, k), 128'(out_valid), 128'(k == int'(S) - 1));
                step();
            end

            // All-ones and most-negative operands in the three signedness mixes.
            issue(ones, ones, 1'b1, 1'b1, TW'(1), PW'(1));
            issue(ones, ones, 1'b0, 1'b0, TW'(2),
                  {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1});
            issue(ones, ones, 1'b1, 1'b0, TW'(3), {{W{1'b1}}, {(W-1){1'b0}}, 1'b1});
            issue(mn, mn, 1'b1, 1'b1, TW'(4), {2'b01, {(PW-2){1'b0}}});
            issue(mn, mn, 1'b0, 1'b0, TW'(5), {2'b01, {(PW-2){1'b0}}});
            issue(mn, mn, 1'b1, 1'b0, TW'(6), {2'b11, {(PW-2){1'b0}}});
            idle();
            drain();

            // Burst of eight with a three-cycle consumer stall once results appear.
            fork
                begin
                    for (int i = 0; i < 8; i++) begin
                        a = pick(); b = pick();
                        sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
                        issue(a, b, sa, sb, TW'(i), ref_mul(a, b, sa, sb));
                    end
                    idle();
                end
                begin
                    seen = 1'b0;
                    for (int n = 0; n < 64 && !seen; n++) begin
                        @(negedge clk);
                        seen = out_valid;
                    end
                    if (!seen) fail($sformatf("cfg%0d burst no output", g));
                    step();
                    out_ready = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        @(negedge clk);
                        chk($sformatf("cfg%0d stall in_ready c=%0d", g, c), 128'(in_ready), 128'(0));
                        chk($sformatf("cfg%0d stall out_valid c=%0d", g, c), 128'(out_valid), 128'(1));
                        if (c == 0) begin
                            hd = dest;
                            ht = out_tag;
                        end else begin
                            chk($sformatf("cfg%0d stall dest c=%0d", g, c), 128'(dest), 128'(hd));
                            chk($sformatf("cfg%0d stall tag c=%0d", g, c), 128'(out_tag), 128'(ht));
                        end
                        step();
                    end
                    out_ready = 1'b1;
                end
            join
            drain();

            // Reset with operations in flight and an op presented during reset.
            for (int i = 0; i < 4; i++) begin
                a = pick(); b = pick();
                issue(a, b, 1'b1, 1'b0, TW'(10 + i), ref_mul(a, b, 1'b1, 1'b0));
            end
            rst = 1'b1; src = pick(); sink = pick(); in_tag = TW'(31);
            @(negedge clk);
            exp_d.delete();
            exp_t.delete();
            step();
            rst = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("cfg%0d post-rst out_valid", g), 128'(out_valid), 128'(0));
            chk($sformatf("cfg%0d post-rst dest", g), 128'(dest), 128'(0));
            for (int k = 0; k < int'(S) + 3; k++) begin
                step();
                @(negedge clk);
                chk($sformatf("cfg%0d stale k=%0d", g, k), 128'(out_valid), 128'(0));
            end
            step();
            issue(W'(3), ~W'(4), 1'b1, 1'b1, TW'(9), ~PW'(14));
            idle();
            drain();

            // Random traffic with random flags and handshakes on both sides.
            n_acc = 0;
            cyc_n = 0;
            while (n_acc < NRAND && cyc_n < 60000) begin
                out_ready = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 3) != 0) begin
                    a = pick(); b = pick();
                    sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
                    src = a; sink = b; src_signed = sa; sink_signed = sb;
                    in_tag = TW'($urandom()); in_valid = 1'b1;
                end else begin
                    idle();
                end
                @(negedge clk);
                if (in_valid && in_ready) begin
                    exp_d.push_back(ref_mul(src, sink, src_signed, sink_signed));
                    exp_t.push_back(in_tag);
                    n_acc++;
                end
                step();
                cyc_n++;
            end
            if (n_acc < NRAND) fail($sformatf("cfg%0d random accept budget n=%0d", g, n_acc));
            idle();
            out_ready = 1'b1;
            drain();
            done = 1'b1;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int c = 0; c < 90000; c++) begin
            @(posedge clk);
            if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
        end
        if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done)) fail("global timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
